// File: rtl/light_pkg.sv
// Shared types and constants for the light fader and its channel steppers.
package light_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_e;

    localparam int unsigned CH_W_DEF = 8;
    localparam logic [3*CH_W_DEF-1:0] WHITE = '1;

endpackage

// File: rtl/channel_stepper.sv
// Next value of one colour channel: snaps to target when within STEP,
// otherwise moves STEP toward it; holds when no tick.
module channel_stepper #(
    parameter int unsigned CH_W = 8,
    parameter int unsigned STEP = 16
) (
    input  logic [CH_W-1:0] cur,
    input  logic [CH_W-1:0] tgt,
    input  logic            tick,
    output logic [CH_W-1:0] nxt_c
);

    localparam int unsigned DW = CH_W + 1;

    logic signed [DW-1:0] diff;
    logic        [DW-1:0] mag;

    always_comb begin
        diff  = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag   = diff[DW-1] ? DW'($unsigned(-diff)) : DW'($unsigned(diff));
        nxt_c = cur;
        if (tick) begin
            if (mag <= DW'(STEP)) begin
                nxt_c = tgt;
            end else if (diff[DW-1]) begin
                nxt_c = cur - CH_W'(STEP);
            end else begin
                nxt_c = cur + CH_W'(STEP);
            end
        end
    end

endmodule

// File: rtl/light_fader.sv
// Source selector driving an RGB light, with hard-cut or prescaled
// per-channel crossfade toward the selected colour.
module light_fader
    import light_pkg::*;
#(
    parameter int unsigned CH_W     = CH_W_DEF,
    parameter int unsigned NUM_SRC  = 4,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned STEP_DIV = 4,
    parameter int unsigned STEP     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      fade_en,
    input  logic [SEL_W-1:0]          sel,
    input  logic [NUM_SRC*3*CH_W-1:0] src_flat,
    output logic [3*CH_W-1:0]         light,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned LW = 3 * CH_W;
    localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [LW-1:0] ALL_ONES = '1;

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [LW-1:0]   light_q, light_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [LW-1:0]   target_c;
    logic [LW-1:0]   step_c;
    logic            tick_c;

    // Live source mux; out-of-range select shows white.
    always_comb begin
        target_c = ALL_ONES;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (sel == SEL_W'(i)) begin
                target_c = src_flat[i*LW +: LW];
            end
        end
    end

    assign tick_c = (state_q == FADE) && (presc_q == PW'(STEP_DIV - 1));

    for (genvar c = 0; c < 3; c++) begin : g_ch
        channel_stepper #(
            .CH_W (CH_W),
            .STEP (STEP)
        ) u_step (
            .cur   (light_q[c*CH_W +: CH_W]),
            .tgt   (target_c[c*CH_W +: CH_W]),
            .tick  (tick_c),
            .nxt_c (step_c[c*CH_W +: CH_W])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            light_q <= ALL_ONES;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            light_q <= light_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Mode/FSM next state; enable low freezes everything and suppresses done.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        light_d = light_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (enable) begin
            if (!fade_en) begin
                light_d = target_c;
                state_d = IDLE;
                presc_d = '0;
                busy_d  = 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        busy_d = 1'b0;
                        if (light_q != target_c) begin
                            state_d = FADE;
                            presc_d = '0;
                            busy_d  = 1'b1;
                        end
                    end
                    FADE: begin
                        presc_d = tick_c ? '0 : presc_q + PW'(1);
                        light_d = step_c;
                        busy_d  = 1'b1;
                        // Target may move mid-fade; completion is judged on the post-update value.
                        if (step_c == target_c) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                endcase
            end
        end
    end

    assign light = light_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_light_fader.sv
// Directed bench for light_fader: per-cycle comparison against a behavioural
// model plus hand-computed colour checkpoints.
module tb_light_fader;

    localparam int STEP_DIV = 4;
    localparam int STEP     = 16;

    logic         clk     = 1'b0;
    logic         rst     = 1'b1;
    logic         enable  = 1'b1;
    logic         fade_en = 1'b1;
    logic [2:0]   sel     = 3'd5;
    logic [95:0]  src_flat = {24'h102030, 24'h0000FF, 24'h00FF00, 24'hFF0000};
    logic [23:0]  light;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    light_fader #(
        .CH_W     (8),
        .NUM_SRC  (4),
        .SEL_W    (3),
        .STEP_DIV (STEP_DIV),
        .STEP     (STEP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .fade_en  (fade_en),
        .sel      (sel),
        .src_flat (src_flat),
        .light    (light),
        .busy     (busy),
        .done     (done)
    );

    // Behavioural model: colour as three integers, fade timed by clocks spent fading.
    logic [23:0] m_light = 24'hFFFFFF;
    logic [23:0] m_tgt;
    bit          m_busy  = 1'b0;
    bit          m_done  = 1'b0;
    int          m_cnt   = 0;

    function automatic logic [23:0] tgt_of(input logic [2:0] s, input logic [95:0] f);
        if (int'(s) < 4) return f[int'(s)*24 +: 24];
        return 24'hFFFFFF;
    endfunction

    function automatic logic [23:0] approach(input logic [23:0] cur, input logic [23:0] tgt);
        logic [23:0] res;
        int a, b;
        res = cur;
        for (int c = 0; c < 3; c++) begin
            a = int'(cur[c*8 +: 8]);
            b = int'(tgt[c*8 +: 8]);
            if (b - a > STEP)       a = a + STEP;
            else if (a - b > STEP)  a = a - STEP;
            else                    a = b;
            res[c*8 +: 8] = 8'(a);
        end
        return res;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_light = 24'hFFFFFF;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_cnt   = 0;
        end else if (enable) begin
            m_tgt  = tgt_of(sel, src_flat);
            m_done = 1'b0;
            if (!fade_en) begin
                m_light = m_tgt;
                m_busy  = 1'b0;
                m_cnt   = 0;
            end else if (!m_busy) begin
                if (m_light != m_tgt) begin
                    m_busy = 1'b1;
                    m_cnt  = 0;
                end
            end else begin
                m_cnt = m_cnt + 1;
                if (m_cnt % STEP_DIV == 0) m_light = approach(m_light, m_tgt);
                if (m_light == m_tgt) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else begin
            m_done = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output with the model.
    task automatic step();
        @(negedge clk);
        chk("model_light", 32'(light), 32'(m_light));
        chk("model_busy",  32'(busy),  32'(m_busy));
        chk("model_done",  32'(done),  32'(m_done));
    endtask

    task automatic wait_idle(output int n, output int dn);
        n  = 0;
        dn = 0;
        while (busy && n < 300) begin
            step();
            n++;
            if (done) dn++;
        end
    endtask

    task automatic cut_to_white();
        fade_en = 1'b0;
        sel     = 3'd5;
        step();
        fade_en = 1'b1;
    endtask

    int n, dn;

    initial begin
        // 1. Reset, asynchronous assertion
        #1 rst = 1'b0;
        #2;
        chk("rst_light", 32'(light), 32'h00FFFFFF);
        chk("rst_busy",  32'(busy),  32'h0);
        chk("rst_done",  32'(done),  32'h0);
        step();
        step();
        rst = 1'b1;
        repeat (3) step();
        chk("post_rst_light", 32'(light), 32'h00FFFFFF);
        chk("post_rst_busy",  32'(busy),  32'h0);

        // 2. Hard cut
        fade_en = 1'b0;
        sel = 3'd1;
        step();
        chk("cut_src1", 32'(light), 32'h0000FF00);
        sel = 3'd3;
        step();
        chk("cut_src3", 32'(light), 32'h00102030);
        chk("cut_busy", 32'(busy), 32'h0);
        sel = 3'd4;
        step();
        chk("cut_sel4_white", 32'(light), 32'h00FFFFFF);

        // 3. Fade white -> src2
        fade_en = 1'b1;
        sel = 3'd2;
        step();
        chk("fade_busy_rise", 32'(busy), 32'h1);
        repeat (3) step();
        chk("fade_pre_tick", 32'(light), 32'h00FFFFFF);
        step();
        chk("fade_tick1", 32'(light), 32'h00EFEFFF);
        wait_idle(n, dn);
        chk("fade_len", 32'(n + 4), 32'd64);
        chk("fade_final", 32'(light), 32'h000000FF);
        chk("fade_done_cnt", 32'(dn), 32'd1);
        step();
        chk("fade_done_low", 32'(done), 32'h0);

        // 4. Retarget mid-fade
        cut_to_white();
        sel = 3'd2;
        step();
        repeat (16) step();
        chk("retgt_tick4", 32'(light), 32'h00BFBFFF);
        sel = 3'd3;
        repeat (3) step();
        chk("retgt_hold", 32'(light), 32'h00BFBFFF);
        step();
        chk("retgt_tick5", 32'(light), 32'h00AFAFEF);
        wait_idle(n, dn);
        chk("retgt_final", 32'(light), 32'h00102030);
        chk("retgt_done_cnt", 32'(dn), 32'd1);

        // 5. Freeze
        cut_to_white();
        sel = 3'd2;
        step();
        repeat (6) step();
        chk("frz_before", 32'(light), 32'h00EFEFFF);
        enable = 1'b0;
        repeat (20) step();
        chk("frz_light", 32'(light), 32'h00EFEFFF);
        chk("frz_busy",  32'(busy),  32'h1);
        enable = 1'b1;
        step();
        chk("frz_resume_hold", 32'(light), 32'h00EFEFFF);
        step();
        chk("frz_resume_tick", 32'(light), 32'h00DFDFFF);

        // 6a. Mode switch mid-fade snaps with no done
        fade_en = 1'b0;
        step();
        chk("mode_snap", 32'(light), 32'h000000FF);
        chk("mode_busy", 32'(busy),  32'h0);
        chk("mode_done", 32'(done),  32'h0);

        // Target returns to current light before any tick
        cut_to_white();
        sel = 3'd2;
        step();
        step();
        chk("back_busy", 32'(busy), 32'h1);
        sel = 3'd5;
        step();
        chk("back_exit_busy", 32'(busy), 32'h0);
        chk("back_exit_done", 32'(done), 32'h1);
        chk("back_light", 32'(light), 32'h00FFFFFF);
        step();
        chk("back_done_low", 32'(done), 32'h0);

        // 6b. Reset asserted mid-fade
        sel = 3'd1;
        step();
        repeat (5) step();
        chk("mid_fade_light", 32'(light), 32'h00EFFFEF);
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_light", 32'(light), 32'h00FFFFFF);
        chk("mid_rst_busy",  32'(busy),  32'h0);
        chk("mid_rst_done",  32'(done),  32'h0);
        step();
        rst = 1'b1;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
